// File: rtl/proj_fm_mc_if.sv
// Bus bundle for the multi-channel fragment memory: write stream, release,
// per-channel lookup request/response and buffer status.
interface proj_fm_mc_if #(
    parameter int BUFFER_COUNT      = 4,
    parameter int DEPTH             = 64,
    parameter int BASE_BITS         = 2,
    parameter int CHANNELS          = 2,
    parameter int FRAG_LEN          = 8,
    parameter int INDICE_LEN        = $clog2(DEPTH) + 1,
    parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
);
    localparam int CNT_W = $clog2(BUFFER_COUNT) + 1;

    logic                                     in_valid;
    logic                                     in_ready;
    logic [BASE_BITS-1:0]                     in_wdata;
    logic                                     in_last;
    logic                                     in_release;
    logic [CHANNELS-1:0]                      req_valid;
    logic [CHANNELS*SIGNED_INDICE_LEN-1:0]    req_idx;
    logic [CHANNELS-1:0]                      rsp_valid;
    logic [CHANNELS-1:0]                      rsp_miss;
    logic [CHANNELS*FRAG_LEN*BASE_BITS-1:0]   rsp_frag;
    logic [CNT_W-1:0]                         buf_count;
    logic                                     rd_avail;

    modport master (
        output in_valid, in_wdata, in_last, in_release, req_valid, req_idx,
        input  in_ready, rsp_valid, rsp_miss, rsp_frag, buf_count, rd_avail
    );

    modport slave (
        input  in_valid, in_wdata, in_last, in_release, req_valid, req_idx,
        output in_ready, rsp_valid, rsp_miss, rsp_frag, buf_count, rd_avail
    );
endinterface

// File: rtl/proj_fm_mc.sv
// Ring of BUFFER_COUNT sequence buffers filled by a base stream; CHANNELS ports
// read zero-padded fragments at signed offsets from the oldest completed buffer.
module proj_fm_mc #(
    parameter int BUFFER_COUNT      = 4,
    parameter int DEPTH             = 64,
    parameter int BASE_BITS         = 2,
    parameter int CHANNELS          = 2,
    parameter int FRAG_LEN          = 8,
    parameter int INDICE_LEN        = $clog2(DEPTH) + 1,
    parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    proj_fm_mc_if.slave bus
);
    localparam int PTR_W  = $clog2(BUFFER_COUNT);
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POS_W  = SIGNED_INDICE_LEN + 1;
    localparam int FRAG_W = FRAG_LEN * BASE_BITS;

    logic [BASE_BITS-1:0]       mem_q [BUFFER_COUNT*DEPTH];
    logic [INDICE_LEN-1:0]      len_q [BUFFER_COUNT];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]              waddr_q, waddr_d;
    logic [CNT_W-1:0]           full_cnt_q, full_cnt_d;
    logic [CHANNELS-1:0]        rsp_valid_q, rsp_valid_d;
    logic [CHANNELS-1:0]        rsp_miss_q, rsp_miss_d;
    logic [CHANNELS*FRAG_W-1:0] rsp_frag_q, rsp_frag_d;
    logic [POS_W-1:0]           pos;
    logic                       wr_accept, wr_complete, rd_release;

    assign bus.in_ready = ~in_rst & (full_cnt_q < CNT_W'(BUFFER_COUNT));
    assign wr_accept    = bus.in_valid & bus.in_ready;
    assign wr_complete  = wr_accept & ((waddr_q == AW'(DEPTH - 1)) | bus.in_last);
    assign rd_release   = bus.in_release & (full_cnt_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        waddr_d    = waddr_q;
        full_cnt_d = full_cnt_q;
        if (wr_accept)   waddr_d  = wr_complete ? '0 : waddr_q + 1'b1;
        if (wr_complete) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_release)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_complete && !rd_release)      full_cnt_d = full_cnt_q + 1'b1;
        else if (!wr_complete && rd_release) full_cnt_d = full_cnt_q - 1'b1;
    end

    // Lookups use pre-update state, so same-cycle completion/release is invisible.
    always_comb begin
        rsp_valid_d = '0;
        rsp_miss_d  = '0;
        rsp_frag_d  = '0;
        pos         = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.req_valid[c]) begin
                if (full_cnt_q == '0) begin
                    rsp_miss_d[c] = 1'b1;
                end else begin
                    rsp_valid_d[c] = 1'b1;
                    for (int i = 0; i < FRAG_LEN; i++) begin
                        pos = POS_W'($signed(bus.req_idx[c*SIGNED_INDICE_LEN +: SIGNED_INDICE_LEN]))
                              + POS_W'(i);
                        if (!pos[POS_W-1] && (pos < POS_W'(len_q[rd_ptr_q])))
                            rsp_frag_d[(c*FRAG_LEN + i)*BASE_BITS +: BASE_BITS] =
                                mem_q[{rd_ptr_q, pos[AW-1:0]}];
                    end
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            waddr_q     <= '0;
            full_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_miss_q  <= '0;
            rsp_frag_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            waddr_q     <= waddr_d;
            full_cnt_q  <= full_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_miss_q  <= rsp_miss_d;
            rsp_frag_q  <= rsp_frag_d;
        end
    end

    // Storage and lengths are never reset; full_cnt gates every read of them.
    always_ff @(posedge in_clk) begin
        if (wr_accept)   mem_q[{wr_ptr_q, waddr_q}] <= bus.in_wdata;
        if (wr_complete) len_q[wr_ptr_q]            <= INDICE_LEN'(waddr_q) + 1'b1;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_miss  = rsp_miss_q;
    assign bus.rsp_frag  = rsp_frag_q;
    assign bus.buf_count = full_cnt_q;
    assign bus.rd_avail  = |full_cnt_q;
endmodule
